// File: rtl/char_conv.sv
// char_conv: MIX CHAR instruction datapath.
// Converts an unsigned WIDTH-bit magnitude into DIGITS MIX character codes
// by iterative shift-add-3 (double-dabble), one input bit per clock.
// out byte k (bits 6k+5:6k) holds decimal digit k (k=0 least significant).
module char_conv #(
  parameter int WIDTH  = 30,
  parameter int DIGITS = 10,
  parameter int CHAR0  = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      in,
  output logic [6*DIGITS-1:0]   out,
  output logic                  busy,
  output logic                  stop
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam logic [5:0]    C0    = 6'(CHAR0);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WIDTH-1:0]        r_bin;
  logic [4*DIGITS-1:0]     r_bcd;
  logic [CW-1:0]           r_cnt;
  logic                    r_stop;
  logic [6*DIGITS-1:0]     r_out;

  logic [4*DIGITS-1:0]     w_adj;
  logic [4*DIGITS-1:0]     w_bcd_nxt;
  logic [WIDTH-1:0]        w_bin_nxt;
  logic [6*DIGITS-1:0]     w_enc;
  logic                    w_last;
  logic                    w_done;

  // Add-3 correction on every nibble >= 5, then shift {bcd,bin} left by one.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_bcd_nxt = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
    w_bin_nxt = {r_bin[WIDTH-2:0], 1'b0};
  end

  // Byte-encode the post-shift BCD value: digit d becomes CHAR0+d.
  always_comb begin
    w_enc = '0;
    for (int unsigned k = 0; k < DIGITS; k++)
      w_enc[6*k +: 6] = C0 + {2'b00, w_bcd_nxt[4*k +: 4]};
  end

  assign w_last = (r_cnt == LAST);
  // A start on the final iteration restarts instead of completing.
  assign w_done = (r_state == RUN) && w_last && !start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: start (re)launches from any state; last iteration returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (!start && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load on start, shift while running, publish result on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_stop <= 1'b0;
      r_out  <= '0;
    end else begin
      r_stop <= w_done;
      if (start) begin
        r_bin <= in;
        r_bcd <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_bin <= w_bin_nxt;
        r_bcd <= w_bcd_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) r_out <= w_enc;
    end
  end

  assign busy = (r_state == RUN);
  assign stop = r_stop;
  assign out  = r_out;

endmodule

// File: tb/tb_char_conv.sv
// Self-checking bench for char_conv: directed corner cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_char_conv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [29:0] in;
  logic [59:0] out;
  logic        busy;
  logic        stop;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stops = 0;
  logic [59:0] held;

  char_conv #(.WIDTH(30), .DIGITS(10), .CHAR0(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in),
    .out   (out),
    .busy  (busy),
    .stop  (stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (stop) n_stops++;

  // Reference: repeated division by ten, digit d -> code 30+d.
  function automatic logic [59:0] model(input logic [29:0] v);
    logic [59:0] m;
    int unsigned x;
    m = '0;
    x = v;
    for (int k = 0; k < 10; k++) begin
      m[6*k +: 6] = 6'(30 + x % 10);
      x = x / 10;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse start with value v, then wait for completion; expects stop exactly
  // 30 edges after the start edge and out held at its previous value until then.
  task automatic run_conv(input logic [29:0] v, input string tag);
    int cyc;
    in    = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in    = 30'($urandom);
    chk({tag, ".busy_on"}, {63'd0, busy}, 64'd1);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!stop && out !== held) chk({tag, ".held"}, {4'd0, out}, {4'd0, held});
    end while (!stop && cyc < 40);
    chk({tag, ".latency"}, 64'(cyc), 64'd30);
    chk({tag, ".out"}, {4'd0, out}, {4'd0, model(v)});
    chk({tag, ".busy_off"}, {63'd0, busy}, 64'd0);
    held = model(v);
  endtask

  task automatic stop_drop(input string tag);
    @(posedge clk); #1;
    chk({tag, ".stop_1cyc"}, {63'd0, stop}, 64'd0);
    chk({tag, ".out_hold"}, {4'd0, out}, {4'd0, held});
  endtask

  initial begin
    logic [29:0] v;
    int s0;
    rst_n = 1'b0;
    start = 1'b0;
    in    = '0;
    held  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.stop", {63'd0, stop}, 64'd0);
    chk("rst.out",  {4'd0, out}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // 1-3: directed values
    run_conv(30'd0, "zero");            stop_drop("zero");
    run_conv(30'd12345, "d12345");      stop_drop("d12345");
    chk("d12345.lit", {4'd0, out}, {4'd0, {6'd30,6'd30,6'd30,6'd30,6'd30,6'd31,6'd32,6'd33,6'd34,6'd35}});
    run_conv(30'h3FFFFFFF, "max");      stop_drop("max");
    chk("max.lit", {4'd0, out}, {4'd0, {6'd31,6'd30,6'd37,6'd33,6'd37,6'd34,6'd31,6'd38,6'd32,6'd33}});

    // 4: abort and restart at cycle 10
    s0 = n_stops;
    @(negedge clk);
    in = 30'd999; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    run_conv(30'd7, "restart");
    chk("restart.single_stop", 64'(n_stops - s0), 64'd0);
    stop_drop("restart");
    chk("restart.stops", 64'(n_stops - s0), 64'd1);

    // 5: async reset mid-run
    @(negedge clk);
    in = 30'd123456; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", {63'd0, busy}, 64'd0);
    chk("arst.stop", {63'd0, stop}, 64'd0);
    chk("arst.out",  {4'd0, out}, 64'd0);
    held = '0;
    @(negedge clk) rst_n = 1'b1;
    s0 = n_stops;
    repeat (40) @(posedge clk);
    #1;
    chk("arst.no_stop", 64'(n_stops - s0), 64'd0);
    run_conv(30'd42, "after_rst");      stop_drop("after_rst");

    // 6: start accepted during the stop cycle
    s0 = n_stops;
    @(negedge clk);
    run_conv(30'd777, "chain_a");
    run_conv(30'd5, "chain_b");
    stop_drop("chain_b");
    chk("chain.stops", 64'(n_stops - s0), 64'd2);

    // random values
    for (int i = 0; i < 8; i++) begin
      v = 30'($urandom);
      if (i == 0) v = 30'd999999999;
      run_conv(v, "rand");
      stop_drop("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
